key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/key_expansion.sv | 92 +++++++++
 tb/tb_key_expansion.sv | 122 ++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// key_expansion: AES-128 round-key generator, one key per accepted handshake.
// Ports: clk_i, rst_n (async active-low); key_i/start_i load a new schedule in IDLE;
// rnd_key_o/rnd_idx_o/valid_o present round keys 0..10, advanced on valid_o&&ready_i;
// busy_o marks RUN; done_o pulses once after key 10 is accepted.
// Optional KEYEXP_STORE_EN keeps all 11 keys, readable via rd_idx_i -> rd_key_o (1-cycle);
// otherwise rd_key_o is tied to 0 and rd_idx_i is ignored.
module key_expansion (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic [127:0] key_i,
  input  logic         start_i,
  input  logic         ready_i,
  output logic [127:0] rnd_key_o,
  output logic [3:0]   rnd_idx_o,
  output logic         valid_o,
  output logic         busy_o,
  output logic         done_o,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic acc, last, load;
  logic [7:0] rcon;
  logic [31:0] w0, w1, w2, w3, rot, sub, w4, w5, w6, w7;
  assign acc = state == RUN && ready_i;
  assign last = rnd_idx_o == 4'd10;
  assign load = state == IDLE && start_i;
  assign valid_o = state == RUN;
  assign busy_o = state == RUN;
  assign {w0, w1, w2, w3} = rnd_key_o;
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sb(rot[31:24]), sb(rot[23:16]), sb(rot[15:8]), sb(rot[7:0])};
  assign w4 = w0 ^ sub ^ {rcon, 24'h0};
  assign w5 = w4 ^ w1;
  assign w6 = w5 ^ w2;
  assign w7 = w6 ^ w3;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (load) state_nx = RUN;
    if (acc && last) state_nx = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      rnd_key_o <= '0;
      rnd_idx_o <= '0;
      done_o <= 1'b0;
      rcon <= 8'h01;
    end else begin
      done_o <= acc && last;
      if (load) begin
        rnd_key_o <= key_i;
        rnd_idx_o <= '0;
        rcon <= 8'h01;
      end else if (acc && !last) begin
        rnd_key_o <= {w4, w5, w6, w7};
        rnd_idx_o <= rnd_idx_o + 4'd1;
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
    end
`ifdef KEYEXP_STORE_EN
  logic [127:0] mem [11];
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) mem[i] <= '0;
      rd_key_o <= '0;
    end else begin
      if (valid_o) mem[rnd_idx_o] <= rnd_key_o;
      rd_key_o <= rd_idx_i > 4'd10 ? '0 : mem[rd_idx_i];
    end
`else
  logic unused_rd;
  assign unused_rd = ^rd_idx_i;
  assign rd_key_o = '0;
`endif
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: table-driven check of the AES-128 key schedule, handshake, reset and store.
module tb_key_expansion;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_n, start_i, ready_i, valid_o, busy_o, done_o;
  logic [127:0] key_i, rnd_key_o, rd_key_o;
  logic [3:0] rnd_idx_o, rd_idx_i;
  key_expansion dut (
    .clk_i(clk_i), .rst_n(rst_n), .key_i(key_i), .start_i(start_i), .ready_i(ready_i),
    .rnd_key_o(rnd_key_o), .rnd_idx_o(rnd_idx_o), .valid_o(valid_o), .busy_o(busy_o),
    .done_o(done_o), .rd_idx_i(rd_idx_i), .rd_key_o(rd_key_o)
  );
  typedef struct {
    logic start;
    logic ready;
    logic [127:0] key;
    logic ev;
    logic ed;
    logic [3:0] ei;
    logic [127:0] ek;
  } vec_t;
  vec_t vt[$];
  logic [127:0] rk [11];
  logic [127:0] k_a, k_z, z_r1;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic add(input logic s, input logic r, input logic [127:0] k, input logic ev,
                     input logic ed, input logic [3:0] ei, input logic [127:0] ek);
    vec_t v;
    v.start = s; v.ready = r; v.key = k; v.ev = ev; v.ed = ed; v.ei = ei; v.ek = ek;
    vt.push_back(v);
  endtask
  function automatic logic [255:0] obs();
    return {121'h0, valid_o, busy_o, done_o, rnd_idx_o, rnd_key_o};
  endfunction
  function automatic logic [255:0] exp_obs(input logic v, input logic d, input logic [3:0] i,
                                           input logic [127:0] k);
    return {121'h0, v, v, d, i, k};
  endfunction
  initial begin
    k_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k_z = '0;
    z_r1 = 128'h62636363626363636263636362636363;
    rk[0]  = k_a;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    add(1, 0, k_a, 1, 0, 0, rk[0]);
    add(1, 1, k_z, 1, 0, 1, rk[1]);
    for (int i = 2; i <= 4; i++) add(0, 1, k_z, 1, 0, i[3:0], rk[i]);
    for (int i = 0; i < 3; i++) add(1, 0, k_z, 1, 0, 4, rk[4]);
    for (int i = 5; i <= 10; i++) add(0, 1, k_z, 1, 0, i[3:0], rk[i]);
    add(1, 1, k_z, 0, 1, 10, rk[10]);
    add(0, 0, k_a, 0, 0, 10, rk[10]);
    add(0, 1, k_a, 0, 0, 10, rk[10]);
    rst_n = 1'b0; start_i = 1'b0; ready_i = 1'b0; key_i = '0; rd_idx_i = '0;
    #1;
    chk("reset_outputs", obs(), exp_obs(0, 0, 0, '0));
    chk("reset_rd_key", {128'h0, rd_key_o}, 256'h0);
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    foreach (vt[n]) begin
      start_i = vt[n].start; ready_i = vt[n].ready; key_i = vt[n].key;
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d", n), obs(), exp_obs(vt[n].ev, vt[n].ed, vt[n].ei, vt[n].ek));
    end
    start_i = 1'b0; ready_i = 1'b0;
    rd_idx_i = 4'd10;
    @(posedge clk_i); #1;
`ifdef KEYEXP_STORE_EN
    chk("rd_idx10", {128'h0, rd_key_o}, {128'h0, rk[10]});
    rd_idx_i = 4'd12;
    @(posedge clk_i); #1;
    chk("rd_idx12", {128'h0, rd_key_o}, 256'h0);
    rd_idx_i = 4'd0;
    @(posedge clk_i); #1;
    chk("rd_idx0", {128'h0, rd_key_o}, {128'h0, rk[0]});
`else
    chk("rd_off10", {128'h0, rd_key_o}, 256'h0);
    rd_idx_i = 4'd0;
    @(posedge clk_i); #1;
    chk("rd_off0", {128'h0, rd_key_o}, 256'h0);
`endif
    start_i = 1'b1; key_i = k_a; ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("rerun_idx0", obs(), exp_obs(1, 0, 0, rk[0]));
    repeat (6) @(posedge clk_i);
    #1;
    chk("rerun_idx6", obs(), exp_obs(1, 0, 6, rk[6]));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", obs(), exp_obs(0, 0, 0, '0));
    chk("async_reset_rd", {128'h0, rd_key_o}, 256'h0);
    repeat (2) begin
      @(posedge clk_i); #1;
      chk("held_reset_no_done", obs(), exp_obs(0, 0, 0, '0));
    end
    rst_n = 1'b1; start_i = 1'b1; key_i = k_z; ready_i = 1'b0;
    @(posedge clk_i); #1;
    chk("fresh_idx0", obs(), exp_obs(1, 0, 0, k_z));
    start_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("fresh_idx1", obs(), exp_obs(1, 0, 1, z_r1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
